// File: rtl/avalon_mem_arbiter.sv
// Purpose: shares one Avalon-MM master port between a read-only fetch requester and a load/store requester.
// Latency: req in cycle 0 -> strobe in cycle 1 -> ack in cycle 2; each waitrequest cycle adds one.
// Backpressure: strobes are held under waitrequest; a stuck slave is aborted after TIMEOUT_CYCLES with err=1.
//
// Ports:
//   clk, reset                     clock, asynchronous active-high reset
//   i_req/i_addr -> i_ack/i_rdata/i_err              fetch requester (read only)
//   d_req/d_write/d_addr/d_wdata/d_byteenable -> d_ack/d_rdata/d_err   data requester
//   address/write/read/writedata/byteenable, waitrequest/readdata      Avalon-MM master
//   busy                           high whenever the arbiter is not idle
module avalon_mem_arbiter #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output logic [31:0] i_rdata,
    output logic        i_err,
    input  logic        d_req,
    input  logic        d_write,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_byteenable,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic [31:0] address,
    output logic        write,
    output logic        read,
    input  logic        waitrequest,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic [31:0] readdata,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, BUS_I, BUS_D, RESP} state_t;
    typedef enum logic {GRANT_FETCH, GRANT_DATA} grant_t;

    // A zero timeout still needs a one-bit counter so the declaration stays legal.
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [CW-1:0] CNT_MAX = '1;

    state_t          state;
    state_t          state_nxt;
    grant_t          last_grant;
    logic [CW-1:0]   tcnt;
    logic            i_elig;
    logic            d_elig;
    logic            grant_i;
    logic            grant_d;
    logic            bus_done;
    logic            bus_abort;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        grant_i   = 1'b0;
        grant_d   = 1'b0;
        bus_done  = 1'b0;
        bus_abort = 1'b0;
        // A requester seeing its own ack must not be re-granted on that same cycle.
        i_elig    = i_req & ~i_ack;
        d_elig    = d_req & ~d_ack;
        case (state)
            IDLE: begin
                if (i_elig && d_elig) begin
                    // Round robin: the side that did not win last time goes next.
                    if (last_grant == GRANT_FETCH) begin
                        grant_d = 1'b1;
                    end else begin
                        grant_i = 1'b1;
                    end
                end else if (d_elig) begin
                    grant_d = 1'b1;
                end else if (i_elig) begin
                    grant_i = 1'b1;
                end
                if (grant_d) begin
                    state_nxt = BUS_D;
                end else if (grant_i) begin
                    state_nxt = BUS_I;
                end
            end
            BUS_I, BUS_D: begin
                if (!waitrequest) begin
                    bus_done  = 1'b1;
                    state_nxt = RESP;
                end else if (TIMEOUT_CYCLES != 0 && tcnt == TO_LAST) begin
                    bus_abort = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            read       <= 1'b0;
            write      <= 1'b0;
            address    <= '0;
            writedata  <= '0;
            byteenable <= '0;
            i_ack      <= 1'b0;
            i_err      <= 1'b0;
            i_rdata    <= '0;
            d_ack      <= 1'b0;
            d_err      <= 1'b0;
            d_rdata    <= '0;
            tcnt       <= '0;
            last_grant <= GRANT_FETCH;
        end else begin
            // Acks and errors are single-cycle pulses, only raised on entry to RESP.
            i_ack <= 1'b0;
            i_err <= 1'b0;
            d_ack <= 1'b0;
            d_err <= 1'b0;

            if (grant_i) begin
                address    <= i_addr;
                writedata  <= '0;
                byteenable <= 4'hF;
                read       <= 1'b1;
                write      <= 1'b0;
                last_grant <= GRANT_FETCH;
                tcnt       <= '0;
            end else if (grant_d) begin
                address    <= d_addr;
                writedata  <= d_wdata;
                byteenable <= d_byteenable;
                read       <= ~d_write;
                write      <= d_write;
                last_grant <= GRANT_DATA;
                tcnt       <= '0;
            end

            if ((state == BUS_I || state == BUS_D) && waitrequest && tcnt != CNT_MAX) begin
                tcnt <= tcnt + 1'b1;
            end

            // Address, writedata and byteenable are left as they were; only strobes drop.
            if (bus_done || bus_abort) begin
                read  <= 1'b0;
                write <= 1'b0;
                if (state == BUS_I) begin
                    i_ack   <= 1'b1;
                    i_err   <= bus_abort;
                    i_rdata <= bus_abort ? '0 : readdata;
                end else begin
                    d_ack   <= 1'b1;
                    d_err   <= bus_abort;
                    d_rdata <= (bus_abort || write) ? '0 : readdata;
                end
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_avalon_mem_arbiter.sv
// Purpose: directed self-checking bench for avalon_mem_arbiter (cycle tables plus corner sequences).
// Latency: inputs driven 1 time unit after a rising edge, outputs sampled 1 unit after the next one.
// Backpressure: waitrequest is driven from the tables and sequences to exercise stall and timeout.
module tb_avalon_mem_arbiter;

    typedef struct packed {
        logic        i_req;
        logic [31:0] i_addr;
        logic        d_req;
        logic        d_write;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic [3:0]  d_be;
        logic        wr;
        logic [31:0] rdata;
    } ins_t;

    typedef struct packed {
        logic        read;
        logic        write;
        logic [31:0] address;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        i_ack;
        logic [31:0] i_rdata;
        logic        i_err;
        logic        d_ack;
        logic [31:0] d_rdata;
        logic        d_err;
        logic        busy;
    } outs_t;

    typedef struct {
        ins_t  in;
        outs_t exp;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        i_err;
    logic        d_req;
    logic        d_write;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_byteenable;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        d_err;
    logic [31:0] address;
    logic        write;
    logic        read;
    logic        waitrequest;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;
    logic        busy;

    int n_checks;
    int n_pass;

    avalon_mem_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .i_req        (i_req),
        .i_addr       (i_addr),
        .i_ack        (i_ack),
        .i_rdata      (i_rdata),
        .i_err        (i_err),
        .d_req        (d_req),
        .d_write      (d_write),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .d_byteenable (d_byteenable),
        .d_ack        (d_ack),
        .d_rdata      (d_rdata),
        .d_err        (d_err),
        .address      (address),
        .write        (write),
        .read         (read),
        .waitrequest  (waitrequest),
        .writedata    (writedata),
        .byteenable   (byteenable),
        .readdata     (readdata),
        .busy         (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic outs_t sample();
        return '{read, write, address, byteenable, writedata, i_ack, i_rdata, i_err,
                 d_ack, d_rdata, d_err, busy};
    endfunction

    task automatic apply(input ins_t v);
        i_req        = v.i_req;
        i_addr       = v.i_addr;
        d_req        = v.d_req;
        d_write      = v.d_write;
        d_addr       = v.d_addr;
        d_wdata      = v.d_wdata;
        d_byteenable = v.d_be;
        waitrequest  = v.wr;
        readdata     = v.rdata;
    endtask

    // One clock; strobes and acks must never overlap in any sampled cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        check("no_overlap", 256'({read & write, i_ack & d_ack}), 256'(2'b00));
    endtask

    vec_t vecs[15];
    ins_t zero_in;
    int   rcnt;
    bit   got;

    initial begin
        n_checks = 0;
        n_pass   = 0;
        zero_in  = '0;
        reset    = 1'b1;
        apply(zero_in);

        // Fields: in  = {i_req,i_addr,d_req,d_write,d_addr,d_wdata,d_be,wr,rdata}
        //         exp = {read,write,address,be,wdata,i_ack,i_rdata,i_err,d_ack,d_rdata,d_err,busy}
        // Fetch alone from 0x04, zero wait.
        vecs[0]  = '{'{1'b1, 32'h04, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0},
                     '{1'b1, 1'b0, 32'h04, 4'hF, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1}};
        vecs[1]  = '{'{1'b1, 32'h04, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h24020010},
                     '{1'b0, 1'b0, 32'h04, 4'hF, 32'h0, 1'b1, 32'h24020010, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1}};
        vecs[2]  = '{'{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0},
                     '{1'b0, 1'b0, 32'h04, 4'hF, 32'h0, 1'b0, 32'h24020010, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0}};
        // Both request together; last grant was fetch, so the load to 0x10 goes first.
        vecs[3]  = '{'{1'b1, 32'h08, 1'b1, 1'b0, 32'h10, 32'h0, 4'hF, 1'b0, 32'h0},
                     '{1'b1, 1'b0, 32'h10, 4'hF, 32'h0, 1'b0, 32'h24020010, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1}};
        vecs[4]  = '{'{1'b1, 32'h08, 1'b1, 1'b0, 32'h10, 32'h0, 4'hF, 1'b0, 32'hDEADBEEF},
                     '{1'b0, 1'b0, 32'h10, 4'hF, 32'h0, 1'b0, 32'h24020010, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b1}};
        vecs[5]  = '{'{1'b1, 32'h08, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0},
                     '{1'b0, 1'b0, 32'h10, 4'hF, 32'h0, 1'b0, 32'h24020010, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0}};
        vecs[6]  = '{'{1'b1, 32'h08, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0},
                     '{1'b1, 1'b0, 32'h08, 4'hF, 32'h0, 1'b0, 32'h24020010, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0, 1'b1}};
        vecs[7]  = '{'{1'b1, 32'h08, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h11112222},
                     '{1'b0, 1'b0, 32'h08, 4'hF, 32'h0, 1'b1, 32'h11112222, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0, 1'b1}};
        vecs[8]  = '{'{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0},
                     '{1'b0, 1'b0, 32'h08, 4'hF, 32'h0, 1'b0, 32'h11112222, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0}};
        // Store 0xA0 to 0x20, be=0011, three stall cycles, then completes with d_rdata=0.
        vecs[9]  = '{'{1'b0, 32'h0, 1'b1, 1'b1, 32'h20, 32'hA0, 4'h3, 1'b0, 32'h0},
                     '{1'b0, 1'b1, 32'h20, 4'h3, 32'hA0, 1'b0, 32'h11112222, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0, 1'b1}};
        vecs[10] = '{'{1'b0, 32'h0, 1'b1, 1'b1, 32'h20, 32'hA0, 4'h3, 1'b1, 32'h0},
                     '{1'b0, 1'b1, 32'h20, 4'h3, 32'hA0, 1'b0, 32'h11112222, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0, 1'b1}};
        vecs[11] = vecs[10];
        vecs[12] = vecs[10];
        vecs[13] = '{'{1'b0, 32'h0, 1'b1, 1'b1, 32'h20, 32'hA0, 4'h3, 1'b0, 32'h55555555},
                     '{1'b0, 1'b0, 32'h20, 4'h3, 32'hA0, 1'b0, 32'h11112222, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1}};
        vecs[14] = '{'{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0},
                     '{1'b0, 1'b0, 32'h20, 4'h3, 32'hA0, 1'b0, 32'h11112222, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0}};

        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 256'(sample()), 256'(outs_t'('0)));
        reset = 1'b0;

        for (int k = 0; k < 15; k++) begin
            apply(vecs[k].in);
            tick();
            check($sformatf("vec%0d", k), 256'(sample()), 256'(vecs[k].exp));
        end

        // Load with waitrequest stuck high: 8 strobe cycles, then an error ack with zero data.
        d_req = 1'b1; d_write = 1'b0; d_addr = 32'h30; d_byteenable = 4'hF;
        waitrequest = 1'b1; readdata = 32'hFFFFFFFF;
        rcnt = 0;
        got  = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            tick();
            if (read) rcnt++;
            if (d_ack) begin
                got = 1'b1;
                check("t4_err", 256'({read, d_err, d_rdata}), 256'({1'b0, 1'b1, 32'h0}));
            end
        end
        check("t4_ack_seen", 256'(got), 256'(1'b1));
        check("t4_read_cycles", 256'(rcnt), 256'(8));
        d_req = 1'b0; waitrequest = 1'b0;
        tick();
        check("t4_idle", 256'({busy, d_ack}), 256'(2'b00));

        // Reset in the middle of a stalled fetch drops the strobe immediately, no ack.
        i_req = 1'b1; i_addr = 32'h40; waitrequest = 1'b1; readdata = 32'h0;
        tick();
        check("t5_strobe", 256'({read, address}), 256'({1'b1, 32'h40}));
        #2 reset = 1'b1;
        #1;
        check("t5_async_drop", 256'({read, busy, i_ack}), 256'(3'b000));
        tick();
        check("t5_in_reset", 256'({read, busy, i_ack}), 256'(3'b000));
        reset = 1'b0; waitrequest = 1'b0; readdata = 32'hCAFEF00D;
        tick();
        check("t5_regrant", 256'({read, address, byteenable}), 256'({1'b1, 32'h40, 4'hF}));
        tick();
        check("t5_ack", 256'({i_ack, i_err, i_rdata}), 256'({1'b1, 1'b0, 32'hCAFEF00D}));
        i_req = 1'b0;
        tick();
        check("t5_idle", 256'({busy, i_ack}), 256'(2'b00));

        // Both held for four transfers: D,I,D,I, three cycles per grant.
        i_req = 1'b1; i_addr = 32'h60;
        d_req = 1'b1; d_write = 1'b0; d_addr = 32'h50; d_byteenable = 4'hF;
        waitrequest = 1'b0; readdata = 32'h100;
        for (int c = 1; c <= 12; c++) begin
            logic d_turn;
            logic ack_cyc;
            d_turn  = (((c - 1) / 3) % 2) == 0;
            ack_cyc = (c % 3) == 2;
            tick();
            check($sformatf("t6_c%0d", c),
                  256'({busy, read, i_ack, d_ack, address}),
                  256'({(c % 3) != 0, (c % 3) == 1, ack_cyc & ~d_turn, ack_cyc & d_turn,
                        (c % 3 == 0) ? address : (d_turn ? 32'h50 : 32'h60)}));
            if (ack_cyc) begin
                check($sformatf("t6_data%0d", c),
                      256'(d_turn ? d_rdata : i_rdata), 256'(32'h100 + 32'(c - 1)));
            end
            if (c == 11) begin
                i_req = 1'b0;
                d_req = 1'b0;
            end
            readdata = 32'h100 + 32'(c);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
